// File: rtl/sqrt_iter.sv
// Iterative unsigned square root: restoring digit-by-digit, one root bit per clock,
// fixed-point result with FRAC_W fraction bits, optional round-half-up on a guard bit.
module sqrt_iter #(
  parameter int  IN_W   = 16,
  parameter int  FRAC_W = 4,
  localparam int OUT_W  = IN_W/2 + FRAC_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic [IN_W-1:0]  in_i,
  input  logic             rnd_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] out_o,
  output logic             exact_o,
  output logic             sat_o
);

  localparam int N     = OUT_W + 1;
  localparam int RAD_W = 2*N;
  localparam int REM_W = 2*N + 2;
  localparam int CNT_W = $clog2(N);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [RAD_W-1:0]   rad_q, rad_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [N-1:0]       root_q, root_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rnd_q, rnd_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               exact_q, exact_d;
  logic               sat_q, sat_d;

  logic [REM_W-1:0]   rem_sh, trial, rem_nx;
  logic [N-1:0]       root_nx;
  logic               ge;
  logic [OUT_W:0]     sum;
  logic               accept;

  assign accept      = (state_q == IDLE) && in_valid_i;
  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign out_o       = out_q;
  assign exact_o     = exact_q;
  assign sat_o       = sat_q;

  // One restoring step: bring down two radicand bits, try (root<<2)|1.
  always_comb begin
    rem_sh  = (rem_q << 2) | REM_W'(rad_q[RAD_W-1 -: 2]);
    trial   = {{(REM_W-N-2){1'b0}}, root_q, 2'b01};
    ge      = (rem_sh >= trial);
    rem_nx  = ge ? (rem_sh - trial) : rem_sh;
    root_nx = {root_q[N-2:0], ge};
    sum     = {1'b0, root_nx[N-1:1]} + (OUT_W+1)'(rnd_q & root_nx[0]);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid_i)     state_d = CALC;
      CALC:    if (cnt_q == '0)    state_d = DONE;
      DONE:    if (out_ready_i)    state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  always_comb begin
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    rnd_d   = rnd_q;
    out_d   = out_q;
    exact_d = exact_q;
    sat_d   = sat_q;
    if (accept) begin
      rad_d  = RAD_W'(in_i) << (2*FRAC_W + 2);
      rem_d  = '0;
      root_d = '0;
      cnt_d  = CNT_W'(N-1);
      rnd_d  = rnd_i;
    end else if (state_q == CALC) begin
      rad_d  = {rad_q[RAD_W-3:0], 2'b00};
      rem_d  = rem_nx;
      root_d = root_nx;
      cnt_d  = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        // sum carries out only when q is all ones and the guard rounds it up
        sat_d   = sum[OUT_W];
        out_d   = sum[OUT_W] ? '1 : sum[OUT_W-1:0];
        exact_d = (rem_nx == '0) && !root_nx[0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      out_q   <= '0;
      exact_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      exact_q <= exact_d;
      sat_q   <= sat_d;
    end
  end

  // Datapath is fully reloaded on every accept, so it carries no reset.
  always_ff @(posedge clk_i) begin
    rad_q  <= rad_d;
    rem_q  <= rem_d;
    root_q <= root_d;
    cnt_q  <= cnt_d;
    rnd_q  <= rnd_d;
  end

endmodule
